// File: rtl/fp_coproc_issue_ctrl_if.sv
// rtl/fp_coproc_issue_ctrl_if.sv - issue, coprocessor and writeback signal bundle
//
// Purpose: groups every non-clock/reset signal of fp_coproc_issue_ctrl.
//   master : the issue controller's view
//   slave  : the surrounding pipeline/coprocessor view
// Signals:
//   issue_*  decode -> controller operation handshake (valid/ready)
//   cp_*     controller <-> coprocessor operands, op, rounding, result, status
//   wb_*     controller -> writeback result handshake (valid/ready)
//   sticky_flags_o, clr_flags_i, busy_o  exception flags and activity
interface fp_coproc_issue_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int STATUS_BIT = 8,
   parameter int TAG_WIDTH  = 4
);
   logic                  issue_valid_i;
   logic                  issue_ready_o;
   logic [DATA_WIDTH-1:0] issue_a_i;
   logic [DATA_WIDTH-1:0] issue_b_i;
   logic                  issue_op_i;
   logic [2:0]            issue_rnd_i;
   logic [TAG_WIDTH-1:0]  issue_tag_i;

   logic [DATA_WIDTH-1:0] cp_input1_o;
   logic [DATA_WIDTH-1:0] cp_input2_o;
   logic                  cp_op_o;
   logic [2:0]            cp_rnd_o;
   logic [DATA_WIDTH-1:0] cp_result_i;
   logic [STATUS_BIT-1:0] cp_status_i;

   logic                  wb_valid_o;
   logic                  wb_ready_i;
   logic [DATA_WIDTH-1:0] wb_data_o;
   logic [STATUS_BIT-1:0] wb_status_o;
   logic [TAG_WIDTH-1:0]  wb_tag_o;

   logic [STATUS_BIT-1:0] sticky_flags_o;
   logic                  clr_flags_i;
   logic                  busy_o;

   modport master (
      input  issue_valid_i, issue_a_i, issue_b_i, issue_op_i, issue_rnd_i, issue_tag_i,
      output issue_ready_o,
      output cp_input1_o, cp_input2_o, cp_op_o, cp_rnd_o,
      input  cp_result_i, cp_status_i,
      output wb_valid_o, wb_data_o, wb_status_o, wb_tag_o,
      input  wb_ready_i,
      output sticky_flags_o, busy_o,
      input  clr_flags_i
   );

   modport slave (
      output issue_valid_i, issue_a_i, issue_b_i, issue_op_i, issue_rnd_i, issue_tag_i,
      input  issue_ready_o,
      input  cp_input1_o, cp_input2_o, cp_op_o, cp_rnd_o,
      output cp_result_i, cp_status_i,
      input  wb_valid_o, wb_data_o, wb_status_o, wb_tag_o,
      output wb_ready_i,
      input  sticky_flags_o, busy_o,
      output clr_flags_i
   );
endinterface

// File: rtl/fp_coproc_issue_ctrl.sv
// rtl/fp_coproc_issue_ctrl.sv - issue controller for the fp16 add/sub coprocessor
//
// Purpose: accepts FP operations from decode, drives registered operands to a
// fixed-latency coprocessor, tracks in-flight operations with a valid/tag pipe,
// queues results in an in-order FWFT FIFO for writeback and accumulates sticky
// exception flags.
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  fp_coproc_issue_ctrl_if.master (issue_*, cp_*, wb_*, sticky/clr/busy)
module fp_coproc_issue_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int STATUS_BIT = 8,
   parameter int TAG_WIDTH  = 4,
   parameter int LATENCY    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   fp_coproc_issue_ctrl_if.master bus
);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int ENTRY_W = DATA_WIDTH + STATUS_BIT + TAG_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   logic                  ready_q;
   logic [CNT_W-1:0]      credits_q, credits_d;
   logic [DATA_WIDTH-1:0] cp_a_q, cp_b_q;
   logic                  cp_op_q;
   logic [2:0]            cp_rnd_q;
   logic [LATENCY:0]      vp_q;
   logic [TAG_WIDTH-1:0]  tp_q [LATENCY+1];
   logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [STATUS_BIT-1:0] sticky_q;

   logic                  accept, push, pop, wb_valid;
   logic [ENTRY_W-1:0]    head;

   assign accept   = bus.issue_valid_i & ready_q;
   assign push     = vp_q[LATENCY];
   assign wb_valid = (count_q != '0);
   assign pop      = wb_valid & bus.wb_ready_i;
   assign head     = mem_q[rd_ptr_q];

   // Credits count accepted-but-not-popped operations, so the FIFO always has
   // room for every result that is still travelling through the coprocessor.
   always_comb begin
      credits_d = credits_q;
      if (accept && !pop) begin
         credits_d = credits_q + CNT_W'(1);
      end else if (!accept && pop) begin
         credits_d = credits_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q   <= 1'b0;
         credits_q <= '0;
         cp_a_q    <= '0;
         cp_b_q    <= '0;
         cp_op_q   <= 1'b0;
         cp_rnd_q  <= '0;
         vp_q      <= '0;
         for (int i = 0; i <= LATENCY; i++) begin
            tp_q[i] <= '0;
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         sticky_q  <= '0;
      end else begin
         credits_q <= credits_d;
         // Ready is the registered decode of the next credit value; it reads 0
         // while in reset and rises on the first edge after release.
         ready_q   <= (credits_d < DEPTH_C);

         if (accept) begin
            cp_a_q   <= bus.issue_a_i;
            cp_b_q   <= bus.issue_b_i;
            cp_op_q  <= bus.issue_op_i;
            cp_rnd_q <= bus.issue_rnd_i;
         end

         // vp/tp[LATENCY] lines up with the coprocessor output register.
         vp_q[0] <= accept;
         tp_q[0] <= bus.issue_tag_i;
         for (int i = 1; i <= LATENCY; i++) begin
            vp_q[i] <= vp_q[i-1];
            tp_q[i] <= tp_q[i-1];
         end

         if (push) begin
            mem_q[wr_ptr_q] <= {bus.cp_result_i, bus.cp_status_i, tp_q[LATENCY]};
            wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (!push && pop) begin
            count_q <= count_q - CNT_W'(1);
         end

         // A clear coinciding with a capture keeps only the new status.
         if (push) begin
            sticky_q <= (bus.clr_flags_i ? '0 : sticky_q) | bus.cp_status_i;
         end else if (bus.clr_flags_i) begin
            sticky_q <= '0;
         end
      end
   end

   assign bus.issue_ready_o  = ready_q;
   assign bus.cp_input1_o    = cp_a_q;
   assign bus.cp_input2_o    = cp_b_q;
   assign bus.cp_op_o        = cp_op_q;
   assign bus.cp_rnd_o       = cp_rnd_q;
   assign bus.wb_valid_o     = wb_valid;
   assign bus.wb_data_o      = head[ENTRY_W-1 -: DATA_WIDTH];
   assign bus.wb_status_o    = head[TAG_WIDTH +: STATUS_BIT];
   assign bus.wb_tag_o       = head[TAG_WIDTH-1:0];
   assign bus.sticky_flags_o = sticky_q;
   assign bus.busy_o         = (credits_q != '0);
endmodule

// File: tb/tb_fp_coproc_issue_ctrl.sv
// tb/tb_fp_coproc_issue_ctrl.sv - self-checking bench for fp_coproc_issue_ctrl
module tb_fp_coproc_issue_ctrl;
   localparam int DW = 16, SW = 8, TW = 4, LAT = 1, DEPTH = 4;
   localparam logic [7:0] ST_OVF = 8'h25; // infinity | huge | inexact

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fp_coproc_issue_ctrl_if #(.DATA_WIDTH(DW), .STATUS_BIT(SW), .TAG_WIDTH(TW)) bus ();

   fp_coproc_issue_ctrl #(
      .DATA_WIDTH(DW), .STATUS_BIT(SW), .TAG_WIDTH(TW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Coprocessor stand-in: known fp16 answers for the directed vectors, a
   // deterministic scramble of the operands otherwise.
   function automatic logic [DW+SW-1:0] fp_unit(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic op, input logic [2:0] rnd);
      case ({a, b, op})
         {16'h3C00, 16'h4000, 1'b0}: return {16'h4200, 8'h00};
         {16'h4200, 16'h3C00, 1'b1}: return {16'h4000, 8'h00};
         {16'h7BFF, 16'h7BFF, 1'b0}: return {16'h7C00, ST_OVF};
         {16'h3C00, 16'h3C00, 1'b0}: return {16'h4000, 8'h00};
         default: return {a ^ {b[7:0], b[15:8]} ^ {12'h0, rnd, op}, a[7:0] ^ b[15:8] ^ {4'h0, rnd, op}};
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.cp_result_i <= '0;
         bus.cp_status_i <= '0;
      end else begin
         {bus.cp_result_i, bus.cp_status_i} <= fp_unit(bus.cp_input1_o, bus.cp_input2_o,
                                                       bus.cp_op_o, bus.cp_rnd_o);
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.issue_valid_i = 1'b0;
      bus.issue_a_i     = '0;
      bus.issue_b_i     = '0;
      bus.issue_op_i    = 1'b0;
      bus.issue_rnd_i   = '0;
      bus.issue_tag_i   = '0;
      bus.wb_ready_i    = 1'b0;
      bus.clr_flags_i   = 1'b0;
   endtask

   task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                         input logic [2:0] rnd, input logic [3:0] tag);
      bus.issue_a_i   = a;
      bus.issue_b_i   = b;
      bus.issue_op_i  = op;
      bus.issue_rnd_i = rnd;
      bus.issue_tag_i = tag;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
      logic [2:0]  rnd;
      logic [3:0]  tag;
      logic [15:0] exp_data;
      logic [7:0]  exp_status;
      logic [7:0]  exp_sticky;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic [7:0]  s;
      logic [3:0]  t;
      int          push_edge;
   } ent_t;

   initial begin
      vec_t        vecs[4];
      logic [15:0] bp_data[5];
      logic [15:0] head_d;
      int          n, acc, pops, first_pop, fifth_acc;
      ent_t        q[$];
      ent_t        e;
      int          cyc;
      logic [7:0]  m_sticky;
      logic [15:0] m_a, m_b;
      logic        m_op;
      logic [2:0]  m_rnd;
      logic        exp_wv, exp_rdy, v, wbr, clr, found;
      logic [7:0]  fst;
      logic [23:0] r;

      vecs[0] = '{16'h3C00, 16'h4000, 1'b0, 3'd0, 4'd3, 16'h4200, 8'h00, 8'h00};
      vecs[1] = '{16'h4200, 16'h3C00, 1'b1, 3'd0, 4'd7, 16'h4000, 8'h00, 8'h00};
      vecs[2] = '{16'h7BFF, 16'h7BFF, 1'b0, 3'd0, 4'd9, 16'h7C00, ST_OVF, ST_OVF};
      vecs[3] = '{16'h3C00, 16'h3C00, 1'b0, 3'd0, 4'd2, 16'h4000, 8'h00, ST_OVF};

      // Reset state
      idle();
      @(negedge clk);
      chk("rst_issue_ready", 32'(bus.issue_ready_o), 0);
      chk("rst_wb_valid", 32'(bus.wb_valid_o), 0);
      chk("rst_busy", 32'(bus.busy_o), 0);
      chk("rst_sticky", 32'(bus.sticky_flags_o), 0);
      chk("rst_cp_input1", 32'(bus.cp_input1_o), 0);
      chk("rst_cp_op_rnd", 32'({bus.cp_op_o, bus.cp_rnd_o}), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.issue_ready_o), 1);

      // Table-driven single operations
      for (int i = 0; i < 4; i++) begin
         chk("vec_ready", 32'(bus.issue_ready_o), 1);
         bus.issue_valid_i = 1'b1;
         bus.wb_ready_i    = 1'b1;
         set_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rnd, vecs[i].tag);
         @(negedge clk);
         bus.issue_valid_i = 1'b0;
         chk("vec_cp_input1", 32'(bus.cp_input1_o), 32'(vecs[i].a));
         chk("vec_cp_input2", 32'(bus.cp_input2_o), 32'(vecs[i].b));
         chk("vec_cp_op_rnd", 32'({bus.cp_op_o, bus.cp_rnd_o}), 32'({vecs[i].op, vecs[i].rnd}));
         chk("vec_busy", 32'(bus.busy_o), 1);
         n = 0;
         while (!bus.wb_valid_o && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("vec_latency", 32'(n), 2);
         chk("vec_data", 32'(bus.wb_data_o), 32'(vecs[i].exp_data));
         chk("vec_status", 32'(bus.wb_status_o), 32'(vecs[i].exp_status));
         chk("vec_tag", 32'(bus.wb_tag_o), 32'(vecs[i].tag));
         chk("vec_sticky", 32'(bus.sticky_flags_o), 32'(vecs[i].exp_sticky));
         @(negedge clk);
         chk("vec_popped", 32'(bus.wb_valid_o), 0);
         chk("vec_idle_busy", 32'(bus.busy_o), 0);
      end

      // Clear coinciding with capture of 1.0+1.0
      bus.issue_valid_i = 1'b1;
      set_op(16'h3C00, 16'h3C00, 1'b0, 3'd0, 4'd5);
      @(negedge clk);
      bus.issue_valid_i = 1'b0;
      @(negedge clk);
      chk("clr_sticky_before", 32'(bus.sticky_flags_o), 32'(ST_OVF));
      bus.clr_flags_i = 1'b1;
      @(negedge clk);
      bus.clr_flags_i = 1'b0;
      chk("clr_capture_valid", 32'(bus.wb_valid_o), 1);
      chk("clr_capture_data", 32'(bus.wb_data_o), 32'h4000);
      chk("clr_capture_sticky", 32'(bus.sticky_flags_o), 0);
      @(negedge clk);

      // Backpressure: five issues into a stalled writeback
      bus.wb_ready_i = 1'b0;
      for (int t = 0; t < 5; t++) begin
         r = fp_unit(16'h1000 + 16'(t), 16'h2000 + 16'(t * 3), 1'(t & 1), 3'(t));
         bp_data[t] = r[23:8];
      end
      acc = 0;
      bus.issue_valid_i = 1'b1;
      set_op(16'h1000, 16'h2000, 1'b0, 3'd0, 4'd0);
      for (int c = 0; c < 8; c++) begin
         v = bus.issue_ready_o;
         @(negedge clk);
         if (v) begin
            acc++;
            set_op(16'h1000 + 16'(acc), 16'h2000 + 16'(acc * 3), 1'(acc & 1), 3'(acc), 4'(acc));
         end
      end
      chk("bp_accepts", 32'(acc), 4);
      chk("bp_ready_low", 32'(bus.issue_ready_o), 0);
      chk("bp_head_valid", 32'(bus.wb_valid_o), 1);
      chk("bp_head_tag", 32'(bus.wb_tag_o), 0);
      head_d = bus.wb_data_o;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_head_stable_data", 32'(bus.wb_data_o), 32'(head_d));
         chk("bp_head_stable_tag", 32'(bus.wb_tag_o), 0);
      end
      bus.wb_ready_i = 1'b1;
      pops = 0;
      first_pop = -1;
      fifth_acc = -1;
      for (int c = 0; c < 20; c++) begin
         if (bus.wb_valid_o) begin
            chk("bp_pop_tag", 32'(bus.wb_tag_o), 32'(pops));
            if (pops < 5) chk("bp_pop_data", 32'(bus.wb_data_o), 32'(bp_data[pops]));
            pops++;
            if (first_pop < 0) first_pop = c;
         end
         v = bus.issue_valid_i & bus.issue_ready_o;
         @(negedge clk);
         if (v) begin
            fifth_acc = c;
            bus.issue_valid_i = 1'b0;
         end
      end
      chk("bp_pop_count", 32'(pops), 5);
      chk("bp_fifth_after_pop", 32'(fifth_acc), 32'(first_pop + 1));
      chk("bp_idle_busy", 32'(bus.busy_o), 0);

      // Accept and pop in the same cycle with three outstanding
      bus.wb_ready_i = 1'b0;
      bus.issue_valid_i = 1'b1;
      set_op(16'h1234, 16'h4321, 1'b1, 3'd2, 4'd8);
      repeat (3) @(negedge clk);
      bus.issue_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("cr_pre_ready", 32'(bus.issue_ready_o), 1);
      chk("cr_pre_valid", 32'(bus.wb_valid_o), 1);
      bus.issue_valid_i = 1'b1;
      bus.wb_ready_i = 1'b1;
      @(negedge clk);
      bus.issue_valid_i = 1'b0;
      bus.wb_ready_i = 1'b0;
      chk("cr_same_ready", 32'(bus.issue_ready_o), 1);
      bus.issue_valid_i = 1'b1;
      @(negedge clk);
      bus.issue_valid_i = 1'b0;
      chk("cr_full_ready", 32'(bus.issue_ready_o), 0);
      bus.wb_ready_i = 1'b1;
      repeat (10) @(negedge clk);
      chk("cr_drain_busy", 32'(bus.busy_o), 0);
      chk("cr_drain_valid", 32'(bus.wb_valid_o), 0);

      // Reset with two operations in flight
      bus.issue_valid_i = 1'b1;
      set_op(16'h5555, 16'h0AAA, 1'b1, 3'd5, 4'd6);
      repeat (2) @(negedge clk);
      bus.issue_valid_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(bus.issue_ready_o), 0);
      chk("mid_rst_busy", 32'(bus.busy_o), 0);
      chk("mid_rst_wb_valid", 32'(bus.wb_valid_o), 0);
      chk("mid_rst_sticky", 32'(bus.sticky_flags_o), 0);
      chk("mid_rst_cp", 32'({bus.cp_input1_o, bus.cp_input2_o}), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("mid_rst_no_wb", 32'(bus.wb_valid_o), 0);
      end
      chk("mid_rst_after_busy", 32'(bus.busy_o), 0);
      chk("mid_rst_after_ready", 32'(bus.issue_ready_o), 1);

      // Randomized traffic against a queue-based reference
      do_reset();
      cyc = 0;
      m_sticky = '0;
      m_a = '0;
      m_b = '0;
      m_op = 1'b0;
      m_rnd = '0;
      for (int it = 0; it < 400; it++) begin
         exp_wv  = (q.size() > 0) && (q[0].push_edge <= cyc);
         exp_rdy = (q.size() < DEPTH);
         chk("rnd_wb_valid", 32'(bus.wb_valid_o), 32'(exp_wv));
         if (exp_wv) begin
            chk("rnd_wb_data", 32'(bus.wb_data_o), 32'(q[0].d));
            chk("rnd_wb_status", 32'(bus.wb_status_o), 32'(q[0].s));
            chk("rnd_wb_tag", 32'(bus.wb_tag_o), 32'(q[0].t));
         end
         chk("rnd_ready", 32'(bus.issue_ready_o), 32'(exp_rdy));
         chk("rnd_busy", 32'(bus.busy_o), 32'(q.size() != 0));
         chk("rnd_sticky", 32'(bus.sticky_flags_o), 32'(m_sticky));
         chk("rnd_cp", 32'({bus.cp_input1_o, bus.cp_input2_o, bus.cp_op_o, bus.cp_rnd_o}),
             32'({m_a, m_b, m_op, m_rnd}));

         v   = ($urandom_range(0, 3) != 0);
         wbr = ($urandom_range(0, 2) != 0);
         clr = ($urandom_range(0, 7) == 0);
         bus.issue_valid_i = v;
         bus.wb_ready_i    = wbr;
         bus.clr_flags_i   = clr;
         set_op(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 4'($urandom));

         found = 1'b0;
         fst = '0;
         foreach (q[k]) begin
            if (q[k].push_edge == cyc + 1) begin
               found = 1'b1;
               fst = q[k].s;
            end
         end
         if (found) m_sticky = (clr ? 8'h00 : m_sticky) | fst;
         else if (clr) m_sticky = 8'h00;
         if (exp_wv && wbr) void'(q.pop_front());
         if (v && exp_rdy) begin
            r = fp_unit(bus.issue_a_i, bus.issue_b_i, bus.issue_op_i, bus.issue_rnd_i);
            e.d = r[23:8];
            e.s = r[7:0];
            e.t = bus.issue_tag_i;
            e.push_edge = cyc + 1 + LAT + 1;
            q.push_back(e);
            m_a = bus.issue_a_i;
            m_b = bus.issue_b_i;
            m_op = bus.issue_op_i;
            m_rnd = bus.issue_rnd_i;
         end
         cyc++;
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fp_coproc_issue_ctrl.md
Name: fp_coproc_issue_ctrl

Overview:
- Pipeline-side master for the 16-bit floating-point add/sub coprocessor.
- Accepts FP operations from the decode stage over a valid/ready handshake and drives registered operands, op and rounding mode to the coprocessor.
- Tracks in-flight operations with a fixed-latency valid/tag pipe and captures each result and status into a result FIFO.
- Returns results in order to writeback over a second valid/ready handshake, and accumulates sticky IEEE exception flags.

Parameters:
- DATA_WIDTH, 16: operand/result width.
- STATUS_BIT, 8: coprocessor status width.
- TAG_WIDTH, 4: destination-register tag width.
- LATENCY, 1: cycles from cp_* update to cp_result_i valid (coprocessor output register).
- FIFO_DEPTH, 4: result FIFO entries; also the maximum outstanding operations. Must be ≥ LATENCY+2 for full throughput.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- issue_valid_i  input  1  decode has an FP operation
- issue_ready_o  output  1  controller can accept an operation
- issue_a_i  input  DATA_WIDTH  operand A
- issue_b_i  input  DATA_WIDTH  operand B
- issue_op_i  input  1  0 = add, 1 = subtract
- issue_rnd_i  input  3  rounding mode
- issue_tag_i  input  TAG_WIDTH  destination tag
- cp_input1_o  output  DATA_WIDTH  registered operand A to coprocessor
- cp_input2_o  output  DATA_WIDTH  registered operand B to coprocessor
- cp_op_o  output  1  registered op
- cp_rnd_o  output  3  registered rounding mode
- cp_result_i  input  DATA_WIDTH  coprocessor result
- cp_status_i  input  STATUS_BIT  coprocessor status
- wb_valid_o  output  1  FIFO head valid
- wb_ready_i  input  1  writeback accepts the head
- wb_data_o  output  DATA_WIDTH  head result
- wb_status_o  output  STATUS_BIT  head status
- wb_tag_o  output  TAG_WIDTH  head tag
- sticky_flags_o  output  STATUS_BIT  OR of all captured status
- clr_flags_i  input  1  clear sticky flags
- busy_o  output  1  any operation outstanding

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs, cp_* registers, valid pipe, FIFO pointers/count, credit counter and sticky flags clear to 0.
  - issue_ready_o goes to 1 once reset is released.
  - Reset mid-operation discards in-flight and queued results; no wb_valid_o follows from them.
- Accept condition: issue_valid_i & issue_ready_o. On the accepting edge:
  - cp_input1/2, cp_op, cp_rnd load from issue_*.
  - vp[0] <= 1 and tp[0] <= issue_tag_i.
  - When not accepting, cp_* hold their values and vp[0] <= 0.
- Valid/tag pipe: vp/tp[0..LATENCY] shift by one stage every cycle. The cycle in which vp[LATENCY]=1 is the cycle in which cp_result_i/cp_status_i belong to that operation.
- Capture: at the end of a cycle with vp[LATENCY]=1, push {cp_result_i, cp_status_i, tp[LATENCY]} into the FIFO.
- Latency: accept edge E0 -> wb_valid_o high after edge E(LATENCY+1); 2 cycles at default.
- Back-to-back accepts are allowed every cycle.
- Credits: counter of accepted operations not yet popped.
  - +1 on accept, -1 on pop; simultaneous accept and pop leaves it unchanged.
  - issue_ready_o = (credits < FIFO_DEPTH), decoded from the register, so the FIFO never overflows.
  - busy_o = (credits != 0).
- FIFO (first-word-fall-through, in-order):
  - Pop on wb_valid_o & wb_ready_i.
  - Push and pop in the same cycle are both performed, including when the FIFO is empty-with-push is not possible by construction.
  - Head outputs hold stable while wb_valid_o=1 and wb_ready_i=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - wb_data_o/wb_status_o/wb_tag_o are don't-care when wb_valid_o=0.
- Sticky flags:
  - On push: sticky <= sticky | cp_status_i.
  - On clr_flags_i without push: sticky <= 0.
  - clr_flags_i and push in the same cycle: sticky <= cp_status_i (clear, then OR).

Test Plan:
- Single add: issue a=0x3C00, b=0x4000, op=0, rnd=0, tag=3, wb_ready=1 -> cp_input1/2 = 0x3C00/0x4000 one cycle after accept; wb_valid_o pulses 2 cycles after accept with data 0x4200, tag 3, status 0x00; busy_o returns to 0 after the pop.
- Backpressure: 5 consecutive issues (tags 0–4) with wb_ready=0 -> issue_ready_o=0 after the 4th accept; 5th held. Raise wb_ready -> tags 0,1,2,3 pop in order; 5th accepted the cycle after the first pop; head stable while stalled.
- Credits edge: credits=3, issue accepted and FIFO popped in the same cycle -> credits stay 3, issue_ready_o stays 1.
- Sticky flags: add 0x7BFF+0x7BFF, rnd=0 -> result 0x7C00, status with infinity/huge/inexact bits set, reflected in sticky_flags_o. Then assert clr_flags_i in the same cycle as capture of 0x3C00+0x3C00 -> sticky equals that operation's status (0x00).
- Subtract: a=0x4200, b=0x3C00, op=1 -> wb_data 0x4000, status 0.
- Reset mid-flight: rst low with 2 operations in flight -> all outputs 0 immediately; after release, no wb_valid_o, busy_o=0, issue_ready_o=1.
